// File: rtl/store_narrow_unit.sv
// Store narrowing unit: lane-replicates byte/half/word store data and runs the memory write handshake.
// Optional alignment fault checking is enabled by defining STORE_ALIGN_CHK_EN.
module store_narrow_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_we,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE, FAULT} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t            state, state_nx;
   logic [31:0]       addr_q, wdata_q;
   logic [1:0]        size_q;
   logic [CNT_W-1:0]  cnt;
   logic              bad_req;
   logic              timed_out;

   always_comb begin
      bad_req = (size == 2'b11);
`ifdef STORE_ALIGN_CHK_EN
      if (size == 2'b01 && addr[0])
         bad_req = 1'b1;
      if (size == 2'b10 && addr[1:0] != 2'b00)
         bad_req = 1'b1;
`endif
   end

   assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req) state_nx = bad_req ? FAULT : ISSUE;
         ISSUE: begin
            // ack on the timeout cycle still completes the store
            if (mem_ack)
               state_nx = DONE;
            else if (timed_out)
               state_nx = FAULT;
         end
         DONE:    state_nx = IDLE;
         FAULT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         cnt     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
         end
         // held at zero outside ISSUE, so it is clear on entry; saturates instead of wrapping
         if (state != ISSUE)
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      err       = (state == FAULT);
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_wdata = '0;
      if (state == ISSUE) begin
         mem_we = 1'b1;
         case (size_q)
            2'b00: begin
               mem_be    = 4'b0001 << addr_q[1:0];
               mem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
               mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
               mem_wdata = {2{wdata_q[15:0]}};
            end
            2'b10: begin
               mem_be    = 4'b1111;
               mem_wdata = wdata_q;
            end
            default: begin
               mem_be    = '0;
               mem_wdata = '0;
            end
         endcase
      end
   end

endmodule
